// File: rtl/voting_seq_tally.sv
// voting_seq_tally: streams one ballot per cycle, tallies per candidate, then scans for the winner.
// Ports: clk, rst (sync, active-high), start, vote_valid/vote/vote_last in, vote_ready out;
// busy, done, winner, winner_count, tie out. Optional tie logic: define VOTING_TIE_DETECT_EN.
module voting_seq_tally #(
   parameter int N = 2,
   parameter int M = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         vote_valid,
   input  logic [N-1:0] vote,
   input  logic         vote_last,
   output logic         vote_ready,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] winner,
   output logic [M:0]   winner_count,
   output logic         tie
);
   localparam int NC = 2**N;
   localparam logic [M:0] CAP = {1'b1, {M{1'b0}}};

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_SCAN    = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]   state;
   logic [M:0]   tally [NC];
   logic [M:0]   total;
   logic [N-1:0] idx;
   logic [M:0]   max_val;
   logic [N-1:0] max_idx;

   logic         accept;
   logic         restart;
   logic         scan_last;
   logic         scan_first;
   logic         greater;
   logic [M:0]   cur;
   logic [M:0]   max_nxt;
   logic [N-1:0] max_idx_nxt;

   assign vote_ready = (state == S_COLLECT) && (total != CAP);
   assign busy       = (state == S_COLLECT) || (state == S_SCAN);
   assign done       = (state == S_DONE);
   assign accept     = vote_valid & vote_ready;
   assign restart    = start && ((state == S_IDLE) || (state == S_DONE));

   assign cur        = tally[idx];
   assign scan_first = (idx == '0);
   assign scan_last  = (idx == N'(NC - 1));
   assign greater    = cur > max_val;

   // Index 0 seeds the running max; later entries replace it only when
   // strictly greater, so equal tallies keep the lowest index.
   always_comb begin
      max_nxt     = max_val;
      max_idx_nxt = max_idx;
      if (scan_first || greater) begin
         max_nxt     = cur;
         max_idx_nxt = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state        <= rst ? S_IDLE : S_COLLECT;
         for (int i = 0; i < NC; i++) tally[i] <= '0;
         total        <= '0;
         idx          <= '0;
         max_val      <= '0;
         max_idx      <= '0;
         winner       <= '0;
         winner_count <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: ;
            S_COLLECT: begin
               if (accept) begin
                  tally[vote] <= tally[vote] + 1'b1;
                  total       <= total + 1'b1;
                  if (vote_last || (total == CAP - 1'b1))
                     state <= S_SCAN;
               end
            end
            S_SCAN: begin
               max_val <= max_nxt;
               max_idx <= max_idx_nxt;
               idx     <= idx + 1'b1;
               if (scan_last) begin
                  state        <= S_DONE;
                  winner       <= max_idx_nxt;
                  winner_count <= max_nxt;
               end
            end
         endcase
      end
   end

`ifdef VOTING_TIE_DETECT_EN
   logic tie_flag;
   logic tie_q;
   logic tie_nxt;

   always_comb begin
      tie_nxt = tie_flag;
      if (scan_first || greater)
         tie_nxt = 1'b0;
      else if (cur == max_val)
         tie_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         tie_flag <= 1'b0;
         tie_q    <= 1'b0;
      end else if (state == S_SCAN) begin
         tie_flag <= tie_nxt;
         if (scan_last) tie_q <= tie_nxt;
      end
   end

   assign tie = tie_q;
`else
   assign tie = 1'b0;
`endif

endmodule

// File: tb/tb_voting_seq_tally.sv
// tb_voting_seq_tally: directed checks of voting_seq_tally (N=2,M=2)
// plus a scaled instance (N=3,M=4) against a tally model.
module tb_voting_seq_tally;
   logic clk = 1'b0;
   logic rst, start, vv, vl, b_start, b_vv, b_vl;
   logic [1:0] vote;
   logic [2:0] b_vote;
   logic a_ready, a_busy, a_done, a_tie;
   logic [1:0] a_win;
   logic [2:0] a_cnt;
   logic b_ready, b_busy, b_done, b_tie;
   logic [2:0] b_win;
   logic [4:0] b_cnt;
   int asserts = 0;
   int fails = 0;

   always #5 clk = ~clk;

   voting_seq_tally #(.N(2), .M(2)) dut_a (
      .clk(clk), .rst(rst), .start(start), .vote_valid(vv), .vote(vote),
      .vote_last(vl), .vote_ready(a_ready), .busy(a_busy), .done(a_done),
      .winner(a_win), .winner_count(a_cnt), .tie(a_tie)
   );

   voting_seq_tally #(.N(3), .M(4)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .vote_valid(b_vv), .vote(b_vote),
      .vote_last(b_vl), .vote_ready(b_ready), .busy(b_busy), .done(b_done),
      .winner(b_win), .winner_count(b_cnt), .tie(b_tie)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cast_a(input logic [1:0] v, input logic last);
      vv = 1'b1; vote = v; vl = last;
      tick();
      vv = 1'b0; vl = 1'b0;
   endtask

   task automatic start_a();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done_a(output int n);
      n = 1;
      while (a_done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      asserts++;
      if ({a_ready, a_busy, a_done, a_tie} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b want 0000", {a_ready, a_busy, a_done, a_tie});
      end
      asserts++;
      if ({a_win, a_cnt} !== 5'd0) begin
         fails++;
         $display("FAIL reset_result: got win=%0d cnt=%0d want 0/0", a_win, a_cnt);
      end
      vv = 1'b1; vote = 2'd1;
      tick();
      vv = 1'b0;
      asserts++;
      if ({a_ready, a_busy} !== 2'b00) begin
         fails++;
         $display("FAIL idle_ignore: got ready/busy=%b want 00", {a_ready, a_busy});
      end
   endtask

   task automatic test_basic();
      int n;
      start_a();
      asserts++;
      if ({a_ready, a_busy} !== 2'b11) begin
         fails++;
         $display("FAIL basic_ready: got ready/busy=%b want 11", {a_ready, a_busy});
      end
      cast_a(2'd1, 1'b0);
      cast_a(2'd1, 1'b0);
      cast_a(2'd2, 1'b0);
      cast_a(2'd3, 1'b1);
      asserts++;
      if ({a_ready, a_busy, a_done} !== 3'b010) begin
         fails++;
         $display("FAIL basic_scan: got ready/busy/done=%b want 010", {a_ready, a_busy, a_done});
      end
      wait_done_a(n);
      asserts++;
      if (n !== 5) begin
         fails++;
         $display("FAIL basic_latency: got %0d want 5", n);
      end
      asserts++;
      if ({a_win, a_cnt, a_tie} !== {2'd1, 3'd2, 1'b0}) begin
         fails++;
         $display("FAIL basic_result: got w=%0d c=%0d t=%0d want 1/2/0", a_win, a_cnt, a_tie);
      end
   endtask

   task automatic test_tie();
      int n;
      logic te;
`ifdef VOTING_TIE_DETECT_EN
      te = 1'b1;
`else
      te = 1'b0;
`endif
      start_a();
      cast_a(2'd2, 1'b0);
      cast_a(2'd0, 1'b0);
      cast_a(2'd0, 1'b0);
      cast_a(2'd2, 1'b1);
      wait_done_a(n);
      asserts++;
      if (n !== 5) begin
         fails++;
         $display("FAIL tie_latency: got %0d want 5", n);
      end
      asserts++;
      if ({a_win, a_cnt, a_tie} !== {2'd0, 3'd2, te}) begin
         fails++;
         $display("FAIL tie_result: got w=%0d c=%0d t=%0d want 0/2/%0d", a_win, a_cnt, a_tie, te);
      end
   endtask

   task automatic test_autoclose();
      int n;
      start_a();
      for (int i = 0; i < 4; i++) cast_a(2'd3, 1'b0);
      asserts++;
      if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
         fails++;
         $display("FAIL auto_ready: got ready=%b busy=%b want 0/1", a_ready, a_busy);
      end
      // keep a fifth ballot offered through SCAN and into DONE
      vv = 1'b1; vote = 2'd1; vl = 1'b1;
      wait_done_a(n);
      tick();
      tick();
      asserts++;
      if (a_done !== 1'b1 || n !== 5) begin
         fails++;
         $display("FAIL auto_done: got done=%b n=%0d want 1/5", a_done, n);
      end
      asserts++;
      if ({a_win, a_cnt, a_tie} !== {2'd3, 3'd4, 1'b0}) begin
         fails++;
         $display("FAIL auto_result: got w=%0d c=%0d t=%0d want 3/4/0", a_win, a_cnt, a_tie);
      end
      vl = 1'b0;
   endtask

   task automatic test_restart();
      int n;
      // start with a ballot in the same cycle: ballot must be dropped
      vv = 1'b1; vote = 2'd1; vl = 1'b0;
      start_a();
      vv = 1'b0;
      asserts++;
      if ({a_done, a_busy, a_win, a_cnt} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
         fails++;
         $display("FAIL restart_clear: got done=%b busy=%b w=%0d c=%0d want 0/1/0/0",
                  a_done, a_busy, a_win, a_cnt);
      end
      cast_a(2'd2, 1'b1);
      wait_done_a(n);
      asserts++;
      if ({a_win, a_cnt, a_done} !== {2'd2, 3'd1, 1'b1}) begin
         fails++;
         $display("FAIL restart_result: got w=%0d c=%0d d=%b want 2/1/1", a_win, a_cnt, a_done);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      start_a();
      cast_a(2'd1, 1'b0);
      cast_a(2'd1, 1'b0);
      rst = 1'b1; start = 1'b1; vv = 1'b1; vote = 2'd1;
      tick();
      rst = 1'b0; start = 1'b0; vv = 1'b0;
      asserts++;
      if ({a_ready, a_busy, a_done, a_win, a_cnt} !== 8'd0) begin
         fails++;
         $display("FAIL midrst_state: got r=%b b=%b d=%b w=%0d c=%0d want all 0",
                  a_ready, a_busy, a_done, a_win, a_cnt);
      end
      start_a();
      cast_a(2'd0, 1'b1);
      wait_done_a(n);
      asserts++;
      if ({a_win, a_cnt, a_done} !== {2'd0, 3'd1, 1'b1}) begin
         fails++;
         $display("FAIL midrst_result: got w=%0d c=%0d d=%b want 0/1/1", a_win, a_cnt, a_done);
      end
   endtask

   task automatic test_scale();
      int cnt [8];
      int best, n, r;
      logic te;
      foreach (cnt[i]) cnt[i] = 0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         r = $urandom_range(0, 7);
         cnt[r]++;
         b_vv = 1'b1; b_vote = 3'(r); b_vl = (i == 15);
         tick();
      end
      b_vv = 1'b0; b_vl = 1'b0;
      best = 0;
      for (int i = 1; i < 8; i++) if (cnt[i] > cnt[best]) best = i;
      te = 1'b0;
`ifdef VOTING_TIE_DETECT_EN
      for (int i = 0; i < 8; i++) if (i != best && cnt[i] == cnt[best]) te = 1'b1;
`endif
      asserts++;
      if (b_ready !== 1'b0) begin
         fails++;
         $display("FAIL scale_ready: got %b want 0", b_ready);
      end
      n = 1;
      while (b_done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      asserts++;
      if (n !== 9) begin
         fails++;
         $display("FAIL scale_latency: got %0d want 9", n);
      end
      asserts++;
      if (b_win !== 3'(best) || b_cnt !== 5'(cnt[best]) || b_tie !== te) begin
         fails++;
         $display("FAIL scale_result: got w=%0d c=%0d t=%0d want %0d/%0d/%0d",
                  b_win, b_cnt, b_tie, best, cnt[best], te);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; vv = 1'b0; vl = 1'b0; vote = '0;
      b_start = 1'b0; b_vv = 1'b0; b_vl = 1'b0; b_vote = '0;
      test_reset();
      test_basic();
      test_tie();
      test_autoclose();
      test_restart();
      test_reset_mid();
      test_scale();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule

// File: doc/voting_seq_tally.md
# voting_seq_tally

Sequential, handshaked successor to the combinational voting core. Ballots stream in one per cycle instead of arriving as one wide vector. Per-candidate tallies are kept in registers, then scanned to find the winner and its vote count. It sits between a ballot source (input FIFO or MPC input stage) and the result consumer, and replaces the flat-vector voting core wherever the voter count is too large to present in parallel.

## Interface
Parameters:
- N, 2, log2 of number of candidates (2**N candidates, indices 0..2**N-1)
- M, 2, log2 of maximum number of voters (at most 2**M ballots per election)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new election; honoured only in IDLE or DONE
- vote_valid  in  1  ballot present on vote
- vote  in  N  candidate index of ballot
- vote_last  in  1  qualifies the current ballot as the final one; sampled only on an accepted ballot
- vote_ready  out  1  block accepts a ballot this cycle
- busy  out  1  election in progress (COLLECT or SCAN)
- done  out  1  result valid; held until next start or rst
- winner  out  N  winning candidate index
- winner_count  out  M+1  ballots received by the winner
- tie  out  1  another candidate matched winner_count (see Configuration)

## Operation
- State machine: IDLE, COLLECT, SCAN, DONE.
- IDLE:
  - vote_ready=0. Ballots are ignored.
  - start → COLLECT. All 2**N tallies, the ballot total and the scan registers are cleared on the same edge.
- COLLECT:
  - vote_ready=1 unless the ballot total has reached 2**M.
  - A ballot is accepted when vote_valid & vote_ready. On acceptance, tally[vote] and total each increment by 1.
  - Tallies and total are M+1 bits wide. They cannot overflow, because ballots are capped at 2**M.
  - Accepted ballot with vote_last=1 → SCAN.
  - Accepted ballot that brings total to 2**M → SCAN, regardless of vote_last.
  - start is ignored.
- SCAN:
  - One candidate is examined per cycle, indices 0 up to 2**N-1.
  - The running max is replaced only if the candidate's tally is strictly greater. Ties therefore resolve to the lowest index.
  - Tie tracking:
    - Equal to the running max: tie flag set.
    - Strictly greater than the running max: tie flag cleared.
  - After index 2**N-1 → DONE. vote_ready=0 and start is ignored.
- DONE:
  - done=1. winner, winner_count and tie are stable.
  - start → COLLECT (new election, same clearing as from IDLE).
- rst in any state:
  - → IDLE.
  - All tallies, total and scan registers cleared.
  - Outputs: vote_ready=0, busy=0, done=0, winner=0, winner_count=0, tie=0.
- winner, winner_count and tie are registered outputs. They update only on the SCAN→DONE transition, and are cleared on start and on rst.
- busy=1 exactly in COLLECT and SCAN.

## Timing
- start sampled at edge t → COLLECT from cycle t+1, vote_ready=1 in cycle t+1.
- Ballot throughput: one per cycle in COLLECT, no bubbles.
- Final ballot accepted at edge k → SCAN occupies cycles k+1 .. k+2**N.
- done=1 from cycle k+2**N+1. Latency from final ballot to result is 2**N+1 cycles.
- vote_ready falls in the cycle after the final ballot is accepted.
- Ballots presented while vote_ready=0 are dropped. The source must hold them; the block never stalls on vote_valid.
- start with vote_valid in the same cycle in DONE: the ballot is not accepted. Counting begins the next cycle.
- rst dominates start and vote_valid in the same cycle.

## Configuration
- Macro: VOTING_TIE_DETECT_EN.
- Defined: the tie output reflects the tie flag computed during SCAN. It is 1 when at least one other candidate's tally equals winner_count.
- Undefined: the tie logic is not synthesised and tie is tied to constant 0. winner and winner_count behaviour is unchanged.

## Test plan
Default parameters N=2, M=2 unless noted.
- Basic: start, then ballots 1,1,2,3 (last on 3) → done after 2**N+1=5 cycles, winner=1, winner_count=2, tie=0.
- Tie: ballots 2,0,0,2 → winner=0, winner_count=2. With VOTING_TIE_DETECT_EN, tie=1; without it, tie=0.
- Auto-close:
  - Four ballots of 3 with vote_last=0 → vote_ready=0 the cycle after the 4th; winner=3, winner_count=4.
  - A 5th vote_valid is not accepted.
- Backpressure and restart:
  - vote_valid=1 held through SCAN and DONE → no tally change.
  - A second start in DONE clears winner/winner_count to 0. A new election with ballot 2 (last) → winner=2, winner_count=1.
- Reset mid-operation: rst asserted in COLLECT after two ballots of 1, then start and single ballot 0 (last) → winner=0, winner_count=1 (the old tallies are gone).
- Scale: N=3, M=4, 16 random ballots → winner/winner_count match a reference model using the lowest-index tie rule; done asserted 9 cycles after the final ballot.
